// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock and flush control for load-use and branch-operand hazards,
// with multi-cycle load stalls and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int LOAD_STALL  = 1,
    parameter int CNT_W       = 16,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              ex_branch_taken,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic {RUN, STALL} state_t;

    state_t            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              m_ex, m_mem, load_use, br_dep, stall, jflush;

    assign m_ex  = ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt))
                   && !(ZERO_REG_EN != 0 && ex_rd == '0);
    assign m_mem = ((id_use_rs && mem_rd == id_rs) || (id_use_rt && mem_rd == id_rt))
                   && !(ZERO_REG_EN != 0 && mem_rd == '0);
    assign load_use = ex_memread && m_ex;
    assign br_dep   = id_branch && ((ex_regwrite && m_ex) || (mem_memread && m_mem));

    // A taken branch overrides any stall; a jump only redirects once the pipe is moving.
    assign stall  = !rst && !ex_branch_taken && (state_q == STALL || load_use || br_dep);
    assign jflush = !rst && !ex_branch_taken && !stall && id_jump;

    assign pc_hold     = stall;
    assign ifid_hold   = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = (!rst && ex_branch_taken) || jflush;
    assign idex_flush  = !rst && ex_branch_taken;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (ex_branch_taken) begin
            state_d = RUN;
            wait_d  = '0;
        end else if (state_q == STALL) begin
            wait_d  = wait_q - 3'd1;
            state_d = (wait_q == 3'd1) ? RUN : STALL;
        end else if (load_use && LOAD_STALL > 1) begin
            state_d = STALL;
            wait_d  = 3'(LOAD_STALL - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(pc_hold && stall_cnt_q != '1);
            flush_cnt_q <= flush_cnt_q + CNT_W'(ifid_flush && flush_cnt_q != '1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl configurations driven in lockstep; per-cycle expectations
// are queued by the stimulus and popped by a negedge monitor.
module tb_hazard_ctrl;
    logic       clk = 0, rst = 1;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       id_use_rs, id_use_rt, id_branch, id_jump;
    logic       ex_memread, ex_regwrite, mem_memread, ex_branch_taken;
    logic        ph_a, ih_a, ib_a, if_a, xf_a, ph_b, ih_b, ib_b, if_b, xf_b;
    logic [15:0] sc_a, fc_a;
    logic [1:0]  sc_b, fc_b;

    typedef struct {
        logic [5:0]  o;
        logic [15:0] sa, fa;
        logic [1:0]  sb, fb;
    } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(16), .ZERO_REG_EN(1)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .ex_branch_taken(ex_branch_taken),
        .pc_hold(ph_a), .ifid_hold(ih_a), .idex_bubble(ib_a), .ifid_flush(if_a),
        .idex_flush(xf_a), .stall_cnt(sc_a), .flush_cnt(fc_a));

    hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .CNT_W(2), .ZERO_REG_EN(0)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_branch(id_branch), .id_jump(id_jump),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .mem_memread(mem_memread), .mem_rd(mem_rd), .ex_branch_taken(ex_branch_taken),
        .pc_hold(ph_b), .ifid_hold(ih_b), .idex_bubble(ib_b), .ifid_flush(if_b),
        .idex_flush(xf_b), .stall_cnt(sc_b), .flush_cnt(fc_b));

    task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    int mcyc = 0;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("a.pc_hold",     mcyc, 16'(ph_a), 16'(e.o[5]));
            chk("a.ifid_hold",   mcyc, 16'(ih_a), 16'(e.o[5]));
            chk("a.idex_bubble", mcyc, 16'(ib_a), 16'(e.o[5]));
            chk("a.ifid_flush",  mcyc, 16'(if_a), 16'(e.o[4]));
            chk("a.idex_flush",  mcyc, 16'(xf_a), 16'(e.o[3]));
            chk("a.stall_cnt",   mcyc, sc_a, e.sa);
            chk("a.flush_cnt",   mcyc, fc_a, e.fa);
            chk("b.pc_hold",     mcyc, 16'(ph_b), 16'(e.o[2]));
            chk("b.ifid_hold",   mcyc, 16'(ih_b), 16'(e.o[2]));
            chk("b.idex_bubble", mcyc, 16'(ib_b), 16'(e.o[2]));
            chk("b.ifid_flush",  mcyc, 16'(if_b), 16'(e.o[1]));
            chk("b.idex_flush",  mcyc, 16'(xf_b), 16'(e.o[0]));
            chk("b.stall_cnt",   mcyc, 16'(sc_b), 16'(e.sb));
            chk("b.flush_cnt",   mcyc, 16'(fc_b), 16'(e.fb));
            mcyc++;
        end
    end

    task automatic clr();
        {id_rs, id_rt, ex_rd, mem_rd} = '0;
        {id_use_rs, id_use_rt, id_branch, id_jump} = '0;
        {ex_memread, ex_regwrite, mem_memread, ex_branch_taken} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    // o = {a_hold, a_ifid_flush, a_idex_flush, b_hold, b_ifid_flush, b_idex_flush}
    task automatic expect_cyc(input logic [5:0] o, input int sa, input int fa, input int sb, input int fb);
        exp_t e;
        e.o = o; e.sa = 16'(sa); e.fa = 16'(fa); e.sb = 2'(sb); e.fb = 2'(fb);
        q.push_back(e);
    endtask

    task automatic load_use();
        ex_memread = 1; ex_rd = 5; id_rs = 5; id_use_rs = 1;
    endtask

    initial begin
        clr();
        rst = 1;
        repeat (2) @(posedge clk);
        tick(); rst = 1; load_use(); ex_branch_taken = 1; id_jump = 1;
        expect_cyc(6'b000_000, 0, 0, 0, 0);
        tick(); rst = 0;           expect_cyc(6'b000_000, 0, 0, 0, 0);
        tick(); load_use();        expect_cyc(6'b100_100, 0, 0, 0, 0);
        tick();                    expect_cyc(6'b100_000, 1, 0, 1, 0);
        tick();                    expect_cyc(6'b100_000, 2, 0, 1, 0);
        tick();                    expect_cyc(6'b000_000, 3, 0, 1, 0);
        tick(); load_use();        expect_cyc(6'b100_100, 3, 0, 1, 0);
        tick(); ex_branch_taken = 1; expect_cyc(6'b011_011, 4, 0, 2, 0);
        tick();                    expect_cyc(6'b000_000, 4, 1, 2, 1);
        tick(); ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
        expect_cyc(6'b000_100, 4, 1, 2, 1);
        tick();                    expect_cyc(6'b000_000, 4, 1, 3, 1);
        tick(); id_branch = 1; id_rt = 7; id_use_rt = 1; mem_memread = 1; mem_rd = 7; id_jump = 1;
        expect_cyc(6'b100_100, 4, 1, 3, 1);
        tick(); id_jump = 1;       expect_cyc(6'b010_010, 5, 1, 3, 1);
        tick();                    expect_cyc(6'b000_000, 5, 2, 3, 2);
        tick(); load_use();        expect_cyc(6'b100_100, 5, 2, 3, 2);
        tick(); rst = 1;           expect_cyc(6'b000_000, 6, 2, 3, 2);
        tick(); rst = 0;           expect_cyc(6'b000_000, 0, 0, 0, 0);
        tick(); load_use(); id_jump = 1; expect_cyc(6'b100_100, 0, 0, 0, 0);
        tick(); id_jump = 1;       expect_cyc(6'b100_010, 1, 0, 1, 0);
        tick(); id_jump = 1;       expect_cyc(6'b100_010, 2, 0, 1, 1);
        tick(); id_jump = 1;       expect_cyc(6'b010_010, 3, 0, 1, 2);
        tick();                    expect_cyc(6'b000_000, 3, 1, 1, 3);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter LOAD_STALL, default 1, legal 1..7: bubbles inserted per load-use hazard (memory latency).
REQ-003 Parameter CNT_W, default 16, performance-counter width.
REQ-004 Parameter ZERO_REG_EN, default 1: when 1, register address 0 never causes a hazard.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 id_rs, id_rt  in  REG_AW each  source registers of the instruction in ID.
REQ-009 id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-010 id_branch, id_jump  in  1 each  ID holds a branch (compared in ID) / jump.
REQ-011 ex_memread, ex_regwrite  in  1 each  EX-stage control.
REQ-012 ex_rd  in  REG_AW  EX destination.
REQ-013 mem_memread  in  1; mem_rd  in  REG_AW  MEM-stage load and destination.
REQ-014 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-015 pc_hold, ifid_hold  out  1 each  hold PC / IF-ID register.
REQ-016 idex_bubble  out  1  zero ID-EX control (insert NOP).
REQ-017 ifid_flush, idex_flush  out  1 each  squash IF-ID / ID-EX contents.
REQ-018 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-019 match(r) = used & (r == id_rs or r == id_rt per use bit) & not (ZERO_REG_EN and r == 0).
REQ-020 load_use = ex_memread & match(ex_rd).
REQ-021 br_dep = id_branch & ((ex_regwrite & match(ex_rd)) | (mem_memread & match(mem_rd))).
REQ-022 FSM states RUN, STALL; one down-counter wait_cnt, 3 bits.
REQ-023 RUN: load_use or br_dep -> pc_hold = ifid_hold = idex_bubble = 1 this cycle (combinational, zero latency).
REQ-024 RUN, load_use and LOAD_STALL > 1 -> next STALL, wait_cnt = LOAD_STALL-1; otherwise stay RUN.
REQ-025 STALL: pc_hold = ifid_hold = idex_bubble = 1; wait_cnt decrements each cycle; at wait_cnt == 1 -> next RUN.
REQ-026 Total hold per load-use hazard = exactly LOAD_STALL cycles.
REQ-027 ex_branch_taken, any state: ifid_flush = idex_flush = 1, pc_hold = ifid_hold = idex_bubble = 0; next RUN, wait_cnt = 0 (abort stall).
REQ-028 id_jump with no stall and no ex_branch_taken -> ifid_flush = 1 for that cycle only, pc not held.
REQ-029 id_jump while stalled -> no flush; the flush occurs in the first non-stalled cycle in which id_jump is still high.
REQ-030 Priority: ex_branch_taken > stall (STALL, load_use, br_dep) > id_jump.
REQ-031 stall_cnt increments by 1 in every cycle with pc_hold = 1; flush_cnt increments in every cycle with ifid_flush = 1.
REQ-032 Both counters saturate at 2^CNT_W-1 (no wrap).
REQ-033 All outputs are deterministic for X-free inputs; no latches.

Reset
REQ-034 rst high at a rising edge -> state RUN, wait_cnt = 0, stall_cnt = flush_cnt = 0.
REQ-035 While rst is high, pc_hold, ifid_hold, idex_bubble, ifid_flush and idex_flush are all 0, regardless of inputs.
REQ-036 Reset asserted mid-STALL aborts the stall; with rst low again and no hazard, the first cycle has pc_hold = 0.

Verification
REQ-037 LOAD_STALL=1: ex_memread=1, ex_rd=5, id_rs=5, id_use_rs=1 for one cycle -> pc_hold/idex_bubble high exactly 1 cycle; stall_cnt = 1.
REQ-038 LOAD_STALL=3: same hazard -> hold high for cycles 0, 1, 2, low at cycle 3; stall_cnt = 3.
REQ-039 LOAD_STALL=3, ex_branch_taken=1 in second hold cycle -> ifid_flush = idex_flush = 1 and pc_hold = 0 that cycle; RUN next cycle; flush_cnt = 1.
REQ-040 ex_memread=1, ex_rd=0, id_rs=0 with ZERO_REG_EN=1 -> no hold; ZERO_REG_EN=0 -> 1-cycle hold.
REQ-041 id_branch=1, id_rt=7, id_use_rt=1, mem_memread=1, mem_rd=7, together with id_jump=1 -> hold 1 cycle, no flush; next cycle (no hazard) ifid_flush = 1.
REQ-042 CNT_W=2: 5 consecutive hazard cycles -> stall_cnt stays at 3; rst pulse -> 0.
